// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer with jump/branch redirect, post-redirect IF/ID squash window
// and misaligned-target trap to a fixed handler address.
module branch_redirect_ctrl #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   RESET_PC    = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_PC     = 32'h0000_0100,
  parameter int                FLUSH_DEPTH = 2,
  parameter int                CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  jbl_address_out,
  output logic [XLEN-1:0]  jbl_address_in,
  output logic [XLEN-1:0]  fetch_pc,
  output logic             fetch_req,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state, state_n;
  logic [2:0]       fcnt, fcnt_n;
  logic [XLEN-1:0]  fetch_pc_n;
  logic             misalign_n;
  logic [CNT_W-1:0] redirect_cnt_n;
  logic             redirect, aligned, advance;

  assign jbl_address_in = ex_pc;

  // Handshake: fetch_pc is offered while fetch_req is high and is accepted on any
  // edge where imem_ready is high; it only moves on acceptance (stall permitting)
  // or on a redirect, which overrides both stall and backpressure.
  assign redirect = br_valid && (jbl_address_out != ex_pc) && (state == RUN);
  assign aligned  = (jbl_address_out[1:0] == 2'b00);
  assign advance  = fetch_req && imem_ready && !stall;

  always_comb begin
    state_n        = state;
    fcnt_n         = fcnt;
    fetch_pc_n     = fetch_pc;
    misalign_n     = 1'b0;
    redirect_cnt_n = redirect_cnt;

    if (redirect) begin
      state_n = FLUSH;
      fcnt_n  = 3'(FLUSH_DEPTH);
      if (aligned) begin
        fetch_pc_n = jbl_address_out;
        if (redirect_cnt != {CNT_W{1'b1}})
          redirect_cnt_n = redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fetch_pc_n = TRAP_PC;
        misalign_n = 1'b1;
      end
    end else begin
      if (advance)
        fetch_pc_n = fetch_pc + XLEN'(4);
      // The squash window counts wall-clock cycles, independent of stall/ready.
      if (state == FLUSH) begin
        fcnt_n  = fcnt - 3'd1;
        state_n = (fcnt == 3'd1) ? RUN : FLUSH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      fcnt         <= 3'd0;
      fetch_pc     <= RESET_PC;
      fetch_req    <= 1'b0;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_n;
      fcnt         <= fcnt_n;
      fetch_pc     <= fetch_pc_n;
      fetch_req    <= 1'b1;
      misalign     <= misalign_n;
      redirect_cnt <= redirect_cnt_n;
    end
  end

  assign flush = (state == FLUSH);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: sequential fetch, taken/not-taken,
// misaligned trap, stall/backpressure during redirect, async reset, PC wrap.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        imem_ready;
  logic        br_valid;
  logic [31:0] ex_pc;
  logic [31:0] jbl_address_out;
  logic [31:0] jbl_address_in;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        flush;
  logic        misalign;
  logic [15:0] redirect_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_redirect_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .imem_ready      (imem_ready),
    .br_valid        (br_valid),
    .ex_pc           (ex_pc),
    .jbl_address_out (jbl_address_out),
    .jbl_address_in  (jbl_address_in),
    .fetch_pc        (fetch_pc),
    .fetch_req       (fetch_req),
    .flush           (flush),
    .misalign        (misalign),
    .redirect_cnt    (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic fl,
                             input logic ma, input logic [15:0] cnt);
    check({tag, ".pc"},  fetch_pc, pc);
    check({tag, ".fl"},  {31'd0, flush}, {31'd0, fl});
    check({tag, ".ma"},  {31'd0, misalign}, {31'd0, ma});
    check({tag, ".cnt"}, {16'd0, redirect_cnt}, {16'd0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b0; br_valid = 1'b0;
    ex_pc = 32'h0000_1234; jbl_address_out = 32'h0;
    #3;
    check_state("rst", 32'h0, 1'b0, 1'b0, 16'd0);
    check("rst.req", {31'd0, fetch_req}, 32'd0);
    check("jbl_in", jbl_address_in, 32'h0000_1234);

    imem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst.hold_pc", fetch_pc, 32'h0);
    rst_n = 1'b1;

    // Free run
    step(); check("run0.req", {31'd0, fetch_req}, 32'd1); check_state("run0", 32'h0, 0, 0, 0);
    step(); check_state("run1", 32'h4, 0, 0, 0);
    step(); check_state("run2", 32'h8, 0, 0, 0);
    step(); check_state("run3", 32'hC, 0, 0, 0);

    // Taken branch 0x40 -> 0x80; a second redirect in N+1 must be ignored
    br_valid = 1'b1; ex_pc = 32'h40; jbl_address_out = 32'h80;
    check("jbl_in2", jbl_address_in, 32'h40);
    step(); check_state("tk1", 32'h80, 1, 0, 1);
    ex_pc = 32'h44; jbl_address_out = 32'h300;
    step(); check_state("tk2", 32'h84, 1, 0, 1);
    br_valid = 1'b0;
    step(); check_state("tk3", 32'h88, 0, 0, 1);

    // Not taken
    br_valid = 1'b1; ex_pc = 32'h40; jbl_address_out = 32'h40;
    step(); check_state("nt", 32'h8C, 0, 0, 1);

    // Misaligned target traps to 0x100
    jbl_address_out = 32'h82;
    step(); check_state("ma1", 32'h100, 1, 1, 1);
    br_valid = 1'b0;
    step(); check_state("ma2", 32'h104, 1, 0, 1);
    step(); check_state("ma3", 32'h108, 0, 0, 1);

    // Redirect beats stall and backpressure, then PC holds
    stall = 1'b1; imem_ready = 1'b0;
    br_valid = 1'b1; ex_pc = 32'h40; jbl_address_out = 32'h200;
    step(); check_state("st1", 32'h200, 1, 0, 2);
    br_valid = 1'b0;
    step(); check_state("st2", 32'h200, 1, 0, 2);
    step(); check_state("st3", 32'h200, 0, 0, 2);
    stall = 1'b0;
    step(); check_state("st4", 32'h200, 0, 0, 2);
    imem_ready = 1'b1;
    step(); check_state("st5", 32'h204, 0, 0, 2);

    // Asynchronous reset in the second flush cycle
    br_valid = 1'b1; ex_pc = 32'h40; jbl_address_out = 32'h400;
    step(); check_state("rf1", 32'h400, 1, 0, 3);
    br_valid = 1'b0;
    step(); check_state("rf2", 32'h404, 1, 0, 3);
    #2 rst_n = 1'b0;
    #1;
    check_state("rf_async", 32'h0, 0, 0, 0);
    check("rf_async.req", {31'd0, fetch_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap from 0xFFFF_FFFC to 0
    step(); check_state("wr0", 32'h0, 0, 0, 0);
    br_valid = 1'b1; ex_pc = 32'h40; jbl_address_out = 32'hFFFF_FFF8;
    step(); check_state("wr1", 32'hFFFF_FFF8, 1, 0, 1);
    br_valid = 1'b0;
    step(); check_state("wr2", 32'hFFFF_FFFC, 1, 0, 1);
    step(); check_state("wr3", 32'h0, 0, 0, 1);
    step(); check_state("wr4", 32'h4, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
